// File: rtl/joint_step_generator.sv
// joint_step_generator
//   Turns a signed Q3.10 radian joint angle from the atan2 stage into an
//   absolute microstep target. It then drives STEP/DIR to the stepper driver
//   until the tracked position equals that target. There is one instance per
//   SCARA joint.
// Ports
//   clk, reset      system clock, asynchronous active-low reset
//   angle[12:0]     signed Q3.10 radians, sampled when angle_valid is high
//   angle_valid     1-cycle strobe, accepted in every state
//   enable          motion enable; when low, motion stops after the current pulse
//   home            zero the position counter (only acted on in IDLE)
//   step, dir       driver outputs; dir=1 means position increments
//   busy            high in every state except IDLE
//   done            1-cycle pulse when the position reaches the target
//   position        signed current microstep position
//   target          signed current microstep target
module joint_step_generator #(
  parameter int STEPS_PER_RAD      = 509,
  parameter int POS_W              = 16,
  parameter int STEP_HIGH_CYCLES   = 50,
  parameter int STEP_PERIOD_CYCLES = 2500,
  parameter int DIR_SETUP_CYCLES   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [12:0]             angle,
  input  logic                    angle_valid,
  input  logic                    enable,
  input  logic                    home,
  output logic                    step,
  output logic                    dir,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position,
  output logic signed [POS_W-1:0] target
);

  localparam int STEP_LOW_CYCLES = STEP_PERIOD_CYCLES - STEP_HIGH_CYCLES;
  localparam int CNT_W = $clog2(STEP_PERIOD_CYCLES + DIR_SETUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HI_LAST    = CNT_W'(STEP_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LO_LAST    = CNT_W'(STEP_LOW_CYCLES - 1);
  localparam logic signed [11:0] SPR      = 12'(STEPS_PER_RAD);
  localparam logic signed [24:0] POS_MAX  = 25'(2**(POS_W-1) - 1);
  localparam logic signed [24:0] POS_MIN  = -POS_MAX - 25'sd1;
  localparam logic signed [POS_W-1:0] ONE = POS_W'(1);

  typedef enum logic [2:0] {IDLE, DIR_SETUP, STEP_HI, STEP_LO, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     dir_q, dir_d;
  logic                     pend_q, pend_d;
  logic signed [POS_W-1:0]  pos_q, pos_d;
  logic signed [POS_W-1:0]  tgt_q, tgt_d;
  logic signed [12:0]       ang_q, ang_d;
  logic                     ang_vld_q, ang_vld_d;

  // Scaling runs one cycle after the strobe, from the latched angle.
  // Adding 512 before the arithmetic shift rounds halves toward +inf.
  logic signed [24:0]       prod, rnd, shf;
  logic signed [POS_W-1:0]  tgt_sat;
  logic                     need_pos;

  assign prod = $signed(ang_q) * SPR;
  assign rnd  = prod + 25'sd512;
  assign shf  = rnd >>> 10;

  always_comb begin
    tgt_sat = POS_W'(shf);
    if (shf > POS_MAX)      tgt_sat = POS_W'(POS_MAX);
    else if (shf < POS_MIN) tgt_sat = POS_W'(POS_MIN);
  end

  assign need_pos = tgt_q > pos_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    dir_d     = dir_q;
    pend_d    = pend_q;
    pos_d     = pos_q;
    tgt_d     = tgt_q;
    ang_d     = angle_valid ? $signed(angle) : ang_q;
    ang_vld_d = angle_valid;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (home) begin
          pos_d = '0;
        end else if (pend_q && enable) begin
          pend_d = 1'b0;
          if (tgt_q == pos_q) begin
            state_d = DONE;
          end else begin
            dir_d   = need_pos;
            state_d = DIR_SETUP;
          end
        end
      end
      DIR_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = STEP_HI;
        end
      end
      STEP_HI: begin
        // The position is updated as the pulse ends, so an enable drop
        // never cuts a pulse short.
        if (cnt_q == HI_LAST) begin
          cnt_d   = '0;
          pos_d   = dir_q ? pos_q + ONE : pos_q - ONE;
          state_d = STEP_LO;
        end
      end
      STEP_LO: begin
        if (cnt_q == LO_LAST) begin
          cnt_d = '0;
          if (!enable) begin
            // Keep the move pending so that re-enabling resumes it.
            pend_d  = 1'b1;
            state_d = IDLE;
          end else if (pos_q == tgt_q) begin
            pend_d  = 1'b0;
            state_d = DONE;
          end else if (need_pos != dir_q) begin
            dir_d   = need_pos;
            state_d = DIR_SETUP;
          end else begin
            state_d = STEP_HI;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A new target takes priority over any pend clear made above.
    if (ang_vld_q) begin
      tgt_d  = tgt_sat;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      pend_q    <= 1'b0;
      pos_q     <= '0;
      tgt_q     <= '0;
      ang_q     <= '0;
      ang_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      pos_q     <= pos_d;
      tgt_q     <= tgt_d;
      ang_q     <= ang_d;
      ang_vld_q <= ang_vld_d;
    end
  end

  // These outputs decode the state directly, so step drops as soon as
  // reset is asserted, without waiting for a clock.
  assign step     = (state_q == STEP_HI);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign dir      = dir_q;
  assign position = pos_q;
  assign target   = tgt_q;

endmodule

// File: tb/tb_joint_step_generator.sv
// tb_joint_step_generator
//   Drives angle strobes into joint_step_generator (STEP_HIGH=2, PERIOD=5,
//   DIR_SETUP=1). It compares the resulting targets, positions, pulse counts
//   and pulse shapes against an arithmetic reference model.
module tb_joint_step_generator;

  logic               clk = 1'b0;
  logic               reset;
  logic [12:0]        angle;
  logic               angle_valid;
  logic               enable;
  logic               home;
  logic               step, dir, busy, done;
  logic signed [15:0] position, target;

  int nvec = 0;
  int nerr = 0;

  joint_step_generator #(
    .STEPS_PER_RAD(509), .POS_W(16), .STEP_HIGH_CYCLES(2),
    .STEP_PERIOD_CYCLES(5), .DIR_SETUP_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .angle(angle), .angle_valid(angle_valid),
    .enable(enable), .home(home), .step(step), .dir(dir), .busy(busy),
    .done(done), .position(position), .target(target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference target: floor((a*509 + 512) / 1024), clamped to 16-bit signed.
  function automatic int exp_tgt(input logic [12:0] v);
    int a, p, q;
    a = v[12] ? int'(v) - 8192 : int'(v);
    p = a * 509 + 512;
    q = (p >= 0) ? p / 1024 : -((-p + 1023) / 1024);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  // Pulse monitor. It counts pulses and done pulses and integrates position.
  // It also checks the pulse high width, the minimum low gap, and that dir
  // is stable for a cycle before every rise.
  int pulses_tot = 0, dones_tot = 0, model_pos = 0;
  int hi_len = 0, lo_len = 0;
  logic prev_step = 1'b0, prev_dir = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_step = 1'b0; prev_dir = 1'b0; hi_len = 0; lo_len = 0;
      model_pos = 0;
    end else begin
      if (home && !busy) model_pos = 0;
      if (step && !prev_step) begin
        pulses_tot++;
        model_pos += dir ? 1 : -1;
        chk("dir_setup", int'(dir), int'(prev_dir));
        chk("lo_gap_ge3", int'(lo_len >= 3), 1);
        hi_len = 1;
      end else if (step) begin
        hi_len++;
      end
      if (!step && prev_step) begin
        chk("hi_len", hi_len, 2);
        lo_len = 0;
      end
      if (!step) lo_len++;
      if (done) dones_tot++;
      prev_step = step;
      prev_dir  = dir;
    end
  end

  int p0 = 0, d0 = 0;
  task automatic clr();
    p0 = pulses_tot; d0 = dones_tot;
  endtask
  function automatic int pulses();
    return pulses_tot - p0;
  endfunction
  function automatic int dones();
    return dones_tot - d0;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(input logic [12:0] a);
    angle = a; angle_valid = 1'b1;
    tick();
    angle_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (done) begin seen = 1'b1; break; end
      tick();
    end
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic wait_pulses(input int n, input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (pulses() >= n) begin seen = 1'b1; break; end
      tick();
    end
    chk("pulses_reached", int'(seen), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] av;
    logic [12:0] rnd_tab [3];
    int e, d, prev;
    bit idle_seen;

    reset = 1'b0; angle = '0; angle_valid = 1'b0; enable = 1'b0; home = 1'b0;
    #1;
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pos", int'(position), 0);
    chk("rst_tgt", int'(target), 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Zero target: done two edges after the strobe, with no steps.
    enable = 1'b1; clr();
    strobe(13'h0000);
    tick();
    chk("zero_n1_busy", int'(busy), 0);
    chk("zero_n1_done", int'(done), 0);
    tick();
    chk("zero_n2_done", int'(done), 1);
    chk("zero_n2_busy", int'(busy), 1);
    tick();
    chk("zero_n3_done", int'(done), 0);
    chk("zero_n3_busy", int'(busy), 0);
    chk("zero_pulses", pulses(), 0);

    // +1.0 rad move.
    clr();
    strobe(13'h0400);
    tick();
    chk("p1_tgt", int'(target), 509);
    chk("p1_n1_busy", int'(busy), 0);
    tick();
    chk("p1_n2_busy", int'(busy), 1);
    chk("p1_n2_dir", int'(dir), 1);
    chk("p1_n2_step", int'(step), 0);
    tick();
    chk("p1_first_rise", int'(step), 1);
    wait_done(4000);
    chk("p1_pos", int'(position), 509);
    chk("p1_model_pos", model_pos, 509);
    chk("p1_pulses", pulses(), 509);
    tick();
    chk("p1_dones", dones(), 1);
    chk("p1_idle", int'(busy), 0);

    // -1.0 rad move from +509.
    clr();
    strobe(13'h1C00);
    tick();
    chk("m1_tgt", int'(target), -509);
    tick();
    chk("m1_dir", int'(dir), 0);
    wait_done(8000);
    chk("m1_pos", int'(position), -509);
    chk("m1_pulses", pulses(), 1018);
    tick();
    chk("m1_dones", dones(), 1);

    // Rounding and random scaling with motion disabled (the move stays pending).
    enable = 1'b0;
    rnd_tab[0] = 13'h0001; rnd_tab[1] = 13'h0002; rnd_tab[2] = 13'h1FFE;
    for (int i = 0; i < 3; i++) begin
      strobe(rnd_tab[i]);
      tick();
      chk("round_tgt", int'(target), exp_tgt(rnd_tab[i]));
    end
    chk("round_fixed_m2", int'(target), -1);
    for (int i = 0; i < 10; i++) begin
      av = (i == 0) ? 13'h0FFF : (i == 1) ? 13'h1000 : 13'($urandom_range(0, 8191));
      strobe(av);
      tick();
      chk("rand_tgt", int'(target), exp_tgt(av));
      chk("held_idle", int'(busy), 0);
    end

    // Home in IDLE.
    home = 1'b1; tick(); home = 1'b0;
    chk("home_pos", int'(position), 0);
    strobe(13'h0000);
    tick();
    clr(); enable = 1'b1;
    wait_done(20);
    chk("home_pulses", pulses(), 0);

    // Random short moves.
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      av = 13'($urandom_range(0, 120)) - 13'd60;
      e = exp_tgt(av);
      clr();
      strobe(av);
      tick(); tick();
      wait_done(500);
      d = (e > prev) ? e - prev : prev - e;
      chk("rmove_pos", int'(position), e);
      chk("rmove_model", model_pos, e);
      chk("rmove_pulses", pulses(), d);
      tick();
      chk("rmove_dones", dones(), 1);
      prev = e;
    end
    strobe(13'h0000);
    tick(); tick();
    wait_done(500);
    tick();

    // Retarget to 0 immediately after the 100th rise on the way to 509.
    clr();
    strobe(13'h0400);
    wait_pulses(100, 1000);
    strobe(13'h0000);
    tick(); tick();
    wait_done(2000);
    chk("rt_pos", int'(position), 0);
    chk("rt_pulses", pulses(), 200);
    tick();
    chk("rt_dones", dones(), 1);

    // Drop enable during the high phase of the 10th pulse.
    clr();
    strobe(13'h0400);
    wait_pulses(10, 200);
    enable = 1'b0;
    chk("en_step_hi", int'(step), 1);
    idle_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy) begin idle_seen = 1'b1; break; end
      tick();
    end
    chk("en_idle", int'(idle_seen), 1);
    chk("en_pos", int'(position), 10);
    repeat (5) tick();
    chk("en_pulses", pulses(), 10);
    chk("en_no_done", dones(), 0);
    chk("en_busy", int'(busy), 0);
    enable = 1'b1;
    wait_done(4000);
    chk("en_resume_pos", int'(position), 509);
    chk("en_resume_pulses", pulses(), 509);
    tick();
    chk("en_dones", dones(), 1);

    // Assert reset during STEP_HI; the outputs must clear before the next edge.
    clr();
    strobe(13'h0000);
    wait_pulses(3, 100);
    reset = 1'b0;
    #1;
    chk("arst_step", int'(step), 0);
    chk("arst_pos", int'(position), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_tgt", int'(target), 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("arst_after_step", int'(step), 0);
    chk("arst_after_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
